acc_act: RTL
============

# acc_act

Post-MVM accumulate-and-activate stage. It sits directly downstream of the stochastic matrix-vector unit:
- It captures the 4 signed up/down-counter results each time an MVM pass finishes.
- It accumulates those results over `TERMS` consecutive passes (one kernel's worth).
- It compares each lane against a folded batch-norm threshold to produce a binary activation vector.
- Activation vectors are buffered in a 2-entry FIFO behind a valid/ready handshake toward the next layer.

## Interface

Parameters:
- `LANES`, 4: parallel lanes; matches MVM output count.
- `IN_W`, 4: width of each MVM result (two's complement).
- `ACC_W`, 8: accumulator width per lane (signed).
- `TERMS`, 9: number of MVM passes summed per activation; legal range 1..255.

Ports. One clock; reset is synchronous and active-high.
- `i_clk_acc`  in  1  clock.
- `i_rst_acc`  in  1  synchronous active-high reset.
- `i_ismvm`  in  1  MVM busy flag; a 1→0 transition marks final results.
- `i_wx [LANES]`  in  `IN_W` each  MVM results; signed.
- `i_thr [LANES]`  in  `ACC_W` each  per-lane signed threshold; sampled at group completion.
- `i_clear`  in  1  abort the current accumulation group.
- `i_act_ready`  in  1  downstream accepts the head of the FIFO.
- `o_act_valid`  out  1  FIFO non-empty.
- `o_act`  out  `LANES`  head activation vector; bit k = lane k.
- `o_busy`  out  1  group partially accumulated (state ACCUM).
- `o_overrun`  out  1  one-cycle pulse: completed vector dropped, FIFO full.
- `o_sat`  out  1  sticky saturation flag (see Configuration).

## Operation

Capture strobe:
- Register `ismvm_r <= i_ismvm`.
- `cap = ismvm_r & ~i_ismvm`. `i_wx` is sampled combinationally in the cap cycle, when the MVM still holds its final count.

FSM states IDLE and ACCUM. Per-lane accumulator `acc[k]` (`ACC_W`) and pass counter `cnt` (8 bits):
- IDLE, cap: `acc = sext(i_wx)`, `cnt = 1`. If `TERMS == 1`, complete and stay IDLE; else go to ACCUM.
- ACCUM, cap: `acc += sext(i_wx)`, `cnt++`. When `cnt` reaches `TERMS`, complete, then clear `acc`/`cnt` and go to IDLE.
- Complete: build vector `v[k] = (acc_next[k] >= i_thr[k])` using a signed compare, then push `v` to the FIFO.
- `i_clear`: zero `acc`/`cnt`, go to IDLE. The FIFO is untouched. Clear and cap in the same cycle: clear wins and the cap is discarded.

Arithmetic:
- Sign-extend each `IN_W` input to `ACC_W`.
- Overflow handling per Configuration.

FIFO (depth 2, storing `LANES` bits per entry):
- Pop on `o_act_valid & i_act_ready`.
- Push on complete.
- Full with simultaneous push and pop: both happen; occupancy stays 2, no overrun.
- Full with push and no pop: vector dropped, `o_overrun` pulses for 1 cycle. Accumulator state still resets to IDLE.
- Empty: `o_act` = 0.

Reset (synchronous, all outputs and state):
- `ismvm_r` = 0, state IDLE, `acc` = 0, `cnt` = 0, FIFO empty.
- `o_act_valid` = 0, `o_act` = 0, `o_busy` = 0, `o_overrun` = 0, `o_sat` = 0.
- Reset asserted mid-group or with a non-empty FIFO discards everything.
- `i_ismvm` high at reset release produces no cap until its next falling edge after one registered high cycle.

## Timing

- Cap detected in cycle N, where `i_ismvm` is low in N and `ismvm_r` is high. Accumulator updates at the end of N.
- Completing cap in cycle N, FIFO previously empty: `o_act_valid` = 1 and `o_act` valid in cycle N+1. Latency is 1 cycle.
- `o_busy` rises in N+1 after the first cap of a group with `TERMS > 1`. It falls in the cycle after the completing cap or after clear.
- Pop takes effect at the clock edge. The next entry, if any, is presented in the following cycle.
- `o_overrun` is high only in cycle N+1 for a dropped push in N.
- Back-to-back caps are possible at 2-cycle minimum spacing, since `i_ismvm` must go high again. No cycle requirement is placed on `i_thr` other than stability in the completing cap cycle.

## Configuration

Macro `ACC_ACT_SAT_EN`:
- Defined: each lane add saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Any clamp sets `o_sat`. `o_sat` stays set until reset (not cleared by `i_clear`).
- Undefined: adds wrap modulo 2^`ACC_W`, and `o_sat` is tied 0.

## Test plan

- Basic group, `TERMS`=3, ready=1: lane0 caps +3,+3,+2 with thr0=8, lane1 caps −1,−1,−1 with thr1=0 → one `o_act_valid` pulse, 1 cycle after the 3rd cap, with bit0=1, bit1=0; `o_busy` high between caps.
- Strobe edge: `i_ismvm` held high across reset release, then low → exactly one cap. `i_ismvm` low for 5 cycles → no further caps.
- FIFO, ready=0: three completed groups → `o_act_valid`=1, 2 entries held, `o_overrun` pulse on the 3rd. Then ready=1 → entries 1 and 2 pop in order, then valid drops.
- Full FIFO with a completing cap and ready=1 in the same cycle → no overrun, occupancy stays 2.
- Clear: `TERMS`=3, 2 caps, then `i_clear` coincident with the 3rd cap → no output, `o_busy`=0. The next 3 caps yield a fresh vector.
- Saturation, `ACC_W`=5, `TERMS`=3, lane0 +7,+7,+7, thr0=0 → with `ACC_ACT_SAT_EN`: acc 15, bit0=1, `o_sat`=1. Without: acc −11, bit0=0, `o_sat`=0.

Source files
------------

// File: rtl/acc_act_if.sv
// Activation-vector handshake toward the next layer.
// The master side drives valid/data; the slave side drives ready.
interface acc_act_if #(
  parameter int LANES = 4
);
  logic             o_act_valid;
  logic [LANES-1:0] o_act;
  logic             i_act_ready;

  modport master (
    output o_act_valid,
    output o_act,
    input  i_act_ready
  );

  modport slave (
    input  o_act_valid,
    input  o_act,
    output i_act_ready
  );
endinterface

// File: rtl/acc_act.sv
// Post-MVM accumulate/threshold stage with a 2-deep activation FIFO.
// Optional macro ACC_ACT_SAT_EN: saturating lane adds and sticky o_sat.
module acc_act #(
  parameter int LANES = 4,
  parameter int IN_W  = 4,
  parameter int ACC_W = 8,
  parameter int TERMS = 9
) (
  input  logic                    i_clk_acc,
  input  logic                    i_rst_acc,
  input  logic                    i_ismvm,
  input  logic signed [IN_W-1:0]  i_wx [LANES],
  input  logic signed [ACC_W-1:0] i_thr [LANES],
  input  logic                    i_clear,
  acc_act_if.master               act_if,
  output logic                    o_busy,
  output logic                    o_overrun,
  output logic                    o_sat
);

`ifdef ACC_ACT_SAT_EN
  localparam int SW = ACC_W + 1;
`else
  localparam int SW = ACC_W;
`endif
  localparam logic [7:0] TERMS_C = 8'(TERMS);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t state;
  state_t state_nxt;

  logic       ismvm_r;
  logic       cap;
  logic       cap_v;
  logic       done;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  logic signed [ACC_W-1:0] acc     [LANES];
  logic signed [ACC_W-1:0] acc_nxt [LANES];
  logic signed [ACC_W-1:0] ext     [LANES];
  logic signed [SW-1:0]    sum     [LANES];
  logic [LANES-1:0]        vec;
`ifdef ACC_ACT_SAT_EN
  logic [LANES-1:0]        clamp;
`endif

  // Falling edge of the busy flag: the MVM still holds its final count.
  assign cap     = ismvm_r & ~i_ismvm;
  assign cap_v   = cap & ~i_clear;
  assign cnt_nxt = (state == IDLE) ? 8'd1 : cnt + 8'd1;
  assign done    = cap_v & (cnt_nxt == TERMS_C);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      ext[k] = {{(ACC_W-IN_W){i_wx[k][IN_W-1]}}, i_wx[k]};
      if (state == IDLE)
        sum[k] = SW'(ext[k]);
      else
        sum[k] = SW'(acc[k]) + SW'(ext[k]);
`ifdef ACC_ACT_SAT_EN
      clamp[k] = sum[k][SW-1] ^ sum[k][SW-2];
      if (clamp[k])
        acc_nxt[k] = sum[k][SW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_nxt[k] = sum[k][ACC_W-1:0];
`else
      acc_nxt[k] = sum[k];
`endif
      vec[k] = (acc_nxt[k] >= i_thr[k]);
    end
  end

  always_ff @(posedge i_clk_acc) begin
    if (i_rst_acc)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      i_clear:        state_nxt = IDLE;
      done:           state_nxt = IDLE;
      cap_v && !done: state_nxt = ACCUM;
      default:        state_nxt = state;
    endcase
  end

  always_comb begin
    o_busy = (state == ACCUM);
  end

  always_ff @(posedge i_clk_acc) begin
    if (i_rst_acc) begin
      ismvm_r <= 1'b0;
      cnt     <= 8'd0;
      for (int k = 0; k < LANES; k++)
        acc[k] <= '0;
    end else begin
      ismvm_r <= i_ismvm;
      if (i_clear || done) begin
        cnt <= 8'd0;
        for (int k = 0; k < LANES; k++)
          acc[k] <= '0;
      end else if (cap_v) begin
        cnt <= cnt_nxt;
        for (int k = 0; k < LANES; k++)
          acc[k] <= acc_nxt[k];
      end
    end
  end

  logic [LANES-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             pop;
  logic             full;
  logic             wr_en;

  assign pop   = act_if.o_act_valid & act_if.i_act_ready;
  assign full  = (count == 2'd2);
  // When full, a same-cycle pop frees the slot the push lands in.
  assign wr_en = done & (~full | pop);

  always_ff @(posedge i_clk_acc) begin
    if (wr_en)
      mem[wr_ptr] <= vec;
  end

  always_ff @(posedge i_clk_acc) begin
    if (i_rst_acc) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      o_overrun <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr ^ pop;
      wr_ptr    <= wr_ptr ^ wr_en;
      count     <= count + {1'b0, wr_en} - {1'b0, pop};
      o_overrun <= done & full & ~pop;
    end
  end

  assign act_if.o_act_valid = (count != 2'd0);
  assign act_if.o_act       = act_if.o_act_valid ? mem[rd_ptr] : '0;

`ifdef ACC_ACT_SAT_EN
  always_ff @(posedge i_clk_acc) begin
    if (i_rst_acc)
      o_sat <= 1'b0;
    else if (cap_v && (|clamp))
      o_sat <= 1'b1;
  end
`else
  assign o_sat = 1'b0;
`endif

endmodule
